// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller request port.
// Read return data is steered back to its issuer via a small FIFO of port ids.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int RD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rdata_valid,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rdata_valid,
    output logic              ctrl_valid,
    input  logic              ctrl_ready,
    output logic              ctrl_rw,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_rdata_valid,
    output logic              rd_err
);

    localparam int PTR_W = $clog2(RD_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RD_DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state;
    logic   rr_ptr;

    logic [RD_DEPTH-1:0] owner;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;

    logic fifo_full;
    logic elig0;
    logic elig1;
    logic grant_valid;
    logic grant_port;
    logic sel_rw;
    logic push;
    logic pop;
    logic head;

    always_comb begin
        fifo_full   = (count == FULL_CNT);
        elig0       = p0_valid && (p0_rw || !fifo_full);
        elig1       = p1_valid && (p1_rw || !fifo_full);
        grant_valid = (state == IDLE) && !rst && (elig0 || elig1);
        // With both eligible rr_ptr decides; otherwise the lone eligible port wins.
        grant_port  = (elig0 && elig1) ? rr_ptr : elig1;
        sel_rw      = grant_port ? p1_rw : p0_rw;
        p0_ready    = grant_valid && !grant_port;
        p1_ready    = grant_valid && grant_port;
        push        = grant_valid && !sel_rw;
        pop         = ctrl_rdata_valid && (count != '0);
        head        = owner[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= 1'b0;
            ctrl_valid     <= 1'b0;
            ctrl_rw        <= 1'b0;
            ctrl_addr      <= '0;
            ctrl_wdata     <= '0;
            owner          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            p0_rdata_valid <= 1'b0;
            p1_rdata_valid <= 1'b0;
            rd_err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ctrl_rw    <= sel_rw;
                        ctrl_addr  <= grant_port ? p1_addr : p0_addr;
                        ctrl_wdata <= grant_port ? p1_wdata : p0_wdata;
                        ctrl_valid <= 1'b1;
                        rr_ptr     <= ~grant_port;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ctrl_ready) begin
                        ctrl_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                owner[wr_ptr] <= grant_port;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Returned data goes only to the head owner; the other port's rdata holds.
            p0_rdata_valid <= pop && !head;
            p1_rdata_valid <= pop && head;
            if (pop && !head) p0_rdata <= ctrl_rdata;
            if (pop && head)  p1_rdata <= ctrl_rdata;

            if (ctrl_rdata_valid && (count == '0)) begin
                rd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: handshake timing, round-robin order,
// backpressure, read routing, FIFO-full blocking and spurious read data.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_ready, p0_rw, p0_rdata_valid;
    logic [22:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_rw, p1_rdata_valid;
    logic [22:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        ctrl_valid, ctrl_ready, ctrl_rw, ctrl_rdata_valid, rd_err;
    logic [22:0] ctrl_addr;
    logic [31:0] ctrl_wdata, ctrl_rdata;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W  (23),
        .DATA_W  (32),
        .RD_DEPTH(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .p0_valid        (p0_valid),
        .p0_ready        (p0_ready),
        .p0_rw           (p0_rw),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_rdata        (p0_rdata),
        .p0_rdata_valid  (p0_rdata_valid),
        .p1_valid        (p1_valid),
        .p1_ready        (p1_ready),
        .p1_rw           (p1_rw),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_rdata        (p1_rdata),
        .p1_rdata_valid  (p1_rdata_valid),
        .ctrl_valid      (ctrl_valid),
        .ctrl_ready      (ctrl_ready),
        .ctrl_rw         (ctrl_rw),
        .ctrl_addr       (ctrl_addr),
        .ctrl_wdata      (ctrl_wdata),
        .ctrl_rdata      (ctrl_rdata),
        .ctrl_rdata_valid(ctrl_rdata_valid),
        .rd_err          (rd_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_valid = 1'b0; p0_rw = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_rw = 1'b0; p1_addr = '0; p1_wdata = '0;
        ctrl_ready = 1'b1; ctrl_rdata = '0; ctrl_rdata_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present one request, wait for its grant, then confirm it reaches the controller.
    task automatic issue(input logic port, input logic rw, input logic [22:0] addr,
                         input logic [31:0] wdata);
        logic got;
        if (port) begin
            p1_valid = 1'b1; p1_rw = rw; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_valid = 1'b1; p0_rw = rw; p0_addr = addr; p0_wdata = wdata;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = port ? p1_ready : p0_ready;
        end
        check("issue_grant", 64'(got), 64'(1));
        @(posedge clk); #1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge clk);
        check("issue_ctrl", 64'({ctrl_valid, ctrl_rw, ctrl_addr}), 64'({1'b1, rw, addr}));
        @(posedge clk); #1;
    endtask

    task automatic ret(input logic [31:0] d, input logic port);
        ctrl_rdata_valid = 1'b1;
        ctrl_rdata       = d;
        @(posedge clk); #1;
        ctrl_rdata_valid = 1'b0;
        @(negedge clk);
        check("ret_pulse", 64'({p1_rdata_valid, p0_rdata_valid}), 64'(port ? 2'b10 : 2'b01));
        check("ret_data", 64'(port ? p1_rdata : p0_rdata), 64'(d));
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned n;
        logic        expp;
        logic        g1;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_outs", 64'({p0_ready, p1_ready, ctrl_valid, ctrl_rw, p0_rdata_valid,
                               p1_rdata_valid, rd_err}), 64'(0));
        check("rst_addr", 64'(ctrl_addr), 64'(0));

        // 1. Single write timing
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 23'h000010; p0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_ready", 64'({p1_ready, p0_ready}), 64'(2'b01));
        check("t1_ctrl_lat", 64'(ctrl_valid), 64'(0));
        @(posedge clk); #1;
        p0_valid = 1'b0;
        @(negedge clk);
        check("t1_ctrl", 64'({ctrl_valid, ctrl_rw, ctrl_addr}), 64'({2'b11, 23'h000010}));
        check("t1_wdata", 64'(ctrl_wdata), 64'(32'hDEADBEEF));
        check("t1_noready", 64'({p1_ready, p0_ready}), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_idle", 64'(ctrl_valid), 64'(0));

        // 2. Contention: alternating grants starting at port 0
        do_reset();
        p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 23'h000000;
        p1_valid = 1'b1; p1_rw = 1'b1; p1_addr = 23'h000100;
        n = 0;
        expp = 1'b0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            @(negedge clk);
            if (p0_ready || p1_ready) begin
                check("t2_dual_ready", 64'(p0_ready && p1_ready), 64'(0));
                check("t2_rr_order", 64'(p1_ready), 64'(expp));
                expp = ~expp;
                n++;
                g1 = p1_ready;
                @(posedge clk); #1;
                if (g1) p1_addr = p1_addr + 1'b1;
                else    p0_addr = p0_addr + 1'b1;
            end
        end
        check("t2_grants", 64'(n), 64'(8));
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // 3. Backpressure
        do_reset();
        ctrl_ready = 1'b0;
        p1_valid = 1'b1; p1_rw = 1'b1; p1_addr = 23'h000055; p1_wdata = 32'h00001234;
        @(negedge clk);
        check("t3_grant", 64'({p1_ready, p0_ready}), 64'(2'b10));
        @(posedge clk); #1;
        p1_valid = 1'b0;
        p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 23'h000066; p0_wdata = 32'h00005678;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_hold", 64'({ctrl_valid, ctrl_addr, ctrl_wdata}),
                  64'({1'b1, 23'h000055, 32'h00001234}));
            check("t3_noready", 64'({p1_ready, p0_ready}), 64'(0));
            @(posedge clk); #1;
        end
        ctrl_ready = 1'b1;
        @(negedge clk);
        check("t3_hs_noready", 64'({ctrl_valid, p1_ready, p0_ready}), 64'(3'b100));
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_next_grant", 64'({p1_ready, p0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        p0_valid = 1'b0;
        @(negedge clk);
        check("t3_next_addr", 64'(ctrl_addr), 64'(23'h000066));
        @(posedge clk); #1;

        // 4. Read routing
        do_reset();
        issue(1'b0, 1'b0, 23'h000100, 32'h0);
        issue(1'b1, 1'b0, 23'h000200, 32'h0);
        issue(1'b0, 1'b0, 23'h000300, 32'h0);
        ret(32'h0000000A, 1'b0);
        ret(32'h0000000B, 1'b1);
        ret(32'h0000000C, 1'b0);
        check("t4_p1_hold", 64'(p1_rdata), 64'(32'h0000000B));
        check("t4_err", 64'(rd_err), 64'(0));

        // 5. FIFO full: reads blocked, writes pass
        do_reset();
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 23'(32'h400 + i), 32'h0);
        p1_valid = 1'b1; p1_rw = 1'b0; p1_addr = 23'h000500;
        p0_valid = 1'b1; p0_rw = 1'b1; p0_addr = 23'h000600; p0_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("t5_write_wins", 64'({p1_ready, p0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        p0_valid = 1'b0;
        @(negedge clk);
        check("t5_write_ctrl", 64'({ctrl_valid, ctrl_rw, ctrl_addr}), 64'({2'b11, 23'h000600}));
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_full_block", 64'({p1_ready, p0_ready}), 64'(0));
        @(posedge clk); #1;
        ctrl_rdata_valid = 1'b1;
        ctrl_rdata       = 32'h00000011;
        @(negedge clk);
        check("t5_still_full", 64'({p1_ready, p0_ready}), 64'(0));
        @(posedge clk); #1;
        ctrl_rdata_valid = 1'b0;
        @(negedge clk);
        check("t5_read_grant", 64'({p1_ready, p0_ready}), 64'(2'b10));
        check("t5_ret", 64'({p1_rdata_valid, p1_rdata}), 64'({1'b1, 32'h00000011}));
        @(posedge clk); #1;
        p1_valid = 1'b0;
        @(negedge clk);
        check("t5_read_ctrl", 64'({ctrl_valid, ctrl_rw, ctrl_addr}), 64'({2'b10, 23'h000500}));
        @(posedge clk); #1;

        // 6. Spurious read data
        do_reset();
        ctrl_rdata_valid = 1'b1;
        ctrl_rdata       = 32'h00000077;
        @(posedge clk); #1;
        ctrl_rdata_valid = 1'b0;
        @(negedge clk);
        check("t6_no_pulse", 64'({p1_rdata_valid, p0_rdata_valid}), 64'(0));
        check("t6_err", 64'(rd_err), 64'(1));
        check("t6_dropped", 64'({p0_rdata, p1_rdata}), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_sticky", 64'(rd_err), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_clear", 64'(rd_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
